// File: rtl/frame_scan_ctrl.sv
// Frame store sequencer: counts one BMP byte stream in, then raster-scans the visible image
// from a ping-pong bank. Define FRAME_SCAN_HBLANK_EN to insert HBLANK idle cycles between lines.
module frame_scan_ctrl #(
    parameter int FRAME_BYTES = 36300,
    parameter int IMG_W       = 300,
    parameter int IMG_H       = 100,
    parameter int HBLANK      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic        stall,
    output logic        IncIndex,
    output logic        readFrame,
    output logic [15:0] FrameWInd,
    output logic [9:0]  PxOut,
    output logic [9:0]  LineOut,
    output logic        RE0,
    output logic        RE1,
    output logic        busy,
    output logic        done
);
    localparam logic [15:0] LOAD_LAST = 16'(FRAME_BYTES - 1);
    localparam logic [9:0]  PX_LAST   = 10'(IMG_W - 1);
    localparam logic [9:0]  LN_LAST   = 10'(IMG_H - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_HBLK, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] load_cnt_q, load_cnt_d;
    logic [9:0]  px_q, px_d, ln_q, ln_d;
    logic [15:0] idx_q, idx_d;
    logic        bank_q, bank_d;
    logic        present;
    logic        rf_q, re0_q, re1_q, busy_q, done_q;
    logic [9:0]  pxo_q, lno_q;
    logic [15:0] idxo_q;
`ifdef FRAME_SCAN_HBLANK_EN
    localparam logic [15:0] HB_LAST = 16'(HBLANK - 1);
    logic [15:0] hb_q, hb_d;
`endif

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        px_d       = px_q;
        ln_d       = ln_q;
        idx_d      = idx_q;
        bank_d     = bank_q;
        present    = 1'b0;
`ifdef FRAME_SCAN_HBLANK_EN
        hb_d       = hb_q;
`endif
        case (state_q)
            // busy_q still high in the cycle after DONE, so a start there is ignored
            S_IDLE: if (start && !busy_q) state_d = S_LOAD;
            S_LOAD: begin
                if (in_valid) begin
                    if (load_cnt_q == LOAD_LAST) begin
                        load_cnt_d = '0;
                        state_d    = S_SCAN;
                    end else begin
                        load_cnt_d = load_cnt_q + 16'd1;
                    end
                end
            end
            S_SCAN: begin
                if (!stall) begin
                    present = 1'b1;
                    if (px_q == PX_LAST) begin
                        px_d = '0;
                        if (ln_q == LN_LAST) begin
                            ln_d    = '0;
                            idx_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            ln_d  = ln_q + 10'd1;
                            idx_d = idx_q + 16'd1;
`ifdef FRAME_SCAN_HBLANK_EN
                            state_d = S_HBLK;
                            hb_d    = '0;
`endif
                        end
                    end else begin
                        px_d  = px_q + 10'd1;
                        idx_d = idx_q + 16'd1;
                    end
                end
            end
`ifdef FRAME_SCAN_HBLANK_EN
            S_HBLK: begin
                if (hb_q == HB_LAST) state_d = S_SCAN;
                else                 hb_d    = hb_q + 16'd1;
            end
`endif
            S_DONE: begin
                bank_d  = ~bank_q;
                px_d    = '0;
                ln_d    = '0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            load_cnt_q <= '0;
            px_q       <= '0;
            ln_q       <= '0;
            idx_q      <= '0;
            bank_q     <= 1'b0;
            rf_q       <= 1'b0;
            pxo_q      <= '0;
            lno_q      <= '0;
            idxo_q     <= '0;
            re0_q      <= 1'b0;
            re1_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            px_q       <= px_d;
            ln_q       <= ln_d;
            idx_q      <= idx_d;
            bank_q     <= bank_d;
            // Outputs show the next pixel to read; readFrame marks the cycles it is actually read
            rf_q       <= present;
            pxo_q      <= px_q;
            lno_q      <= ln_q;
            idxo_q     <= idx_q;
            re0_q      <= (state_q == S_SCAN || state_q == S_HBLK) && !bank_q;
            re1_q      <= (state_q == S_SCAN || state_q == S_HBLK) && bank_q;
            busy_q     <= (state_d != S_IDLE) || (state_q == S_DONE);
            done_q     <= (state_q == S_DONE);
        end
    end

`ifdef FRAME_SCAN_HBLANK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hb_q <= '0;
        else       hb_q <= hb_d;
    end
`endif

    assign IncIndex  = (state_q == S_LOAD) && in_valid;
    assign readFrame = rf_q;
    assign FrameWInd = idxo_q;
    assign PxOut     = pxo_q;
    assign LineOut   = lno_q;
    assign RE0       = re0_q;
    assign RE1       = re1_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule
